// File: rtl/addsub_nibble_seq.sv
// Nibble-serial add/subtract sequencer: one shared 4-bit slice, LSB nibble first,
// carry held in a register between nibbles; start/done handshake to the requester.
module addsub_nibble_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 ASeq_i_Clk,
  input  logic                 ASeq_i_nRst,
  input  logic                 ASeq_i_Start,
  input  logic [4*NIBBLES-1:0] ASeq_i_A,
  input  logic [4*NIBBLES-1:0] ASeq_i_B,
  input  logic                 ASeq_i_fSub,
  output logic                 ASeq_o_Busy,
  output logic                 ASeq_o_Done,
  output logic [4*NIBBLES-1:0] ASeq_o_S,
  output logic                 ASeq_o_C,
  output logic                 ASeq_o_V
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state, nextState;
  logic [W-1:0]  aReg, bReg, work, workNext;
  logic          subReg, carry;
  logic [IW-1:0] idx;
  logic [3:0]    nibA, nibB;
  logic [4:0]    sliceSum;
  logic          accept, lastNib;

  // Shared slice: A + (B ^ {4{fSub}}) + carry on the nibble selected by idx.
  always_comb begin
    nibA     = aReg[{idx, 2'b00} +: 4];
    nibB     = bReg[{idx, 2'b00} +: 4] ^ {4{subReg}};
    sliceSum = {1'b0, nibA} + {1'b0, nibB} + {4'b0000, carry};
    workNext = work;
    workNext[{idx, 2'b00} +: 4] = sliceSum[3:0];
    lastNib  = (idx == LAST);
  end

  always_comb begin
    nextState = state;
    accept    = ASeq_i_Start && ((state == IDLE) || (state == DONE));
    case (state)
      IDLE:    if (accept) nextState = RUN;
      RUN:     if (lastNib) nextState = DONE;
      DONE:    nextState = accept ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge ASeq_i_Clk or negedge ASeq_i_nRst) begin
    if (!ASeq_i_nRst) begin
      state       <= IDLE;
      aReg        <= '0;
      bReg        <= '0;
      subReg      <= 1'b0;
      carry       <= 1'b0;
      idx         <= '0;
      work        <= '0;
      ASeq_o_Busy <= 1'b0;
      ASeq_o_Done <= 1'b0;
      ASeq_o_S    <= '0;
      ASeq_o_C    <= 1'b0;
      ASeq_o_V    <= 1'b0;
    end else begin
      state       <= nextState;
      ASeq_o_Busy <= (nextState == RUN);
      ASeq_o_Done <= (nextState == DONE);
      if (accept) begin
        aReg   <= ASeq_i_A;
        bReg   <= ASeq_i_B;
        subReg <= ASeq_i_fSub;
        carry  <= ASeq_i_fSub;
        idx    <= '0;
        work   <= '0;
      end else if (state == RUN) begin
        work  <= workNext;
        carry <= sliceSum[4];
        // Results are taken from the slice outputs so they land on the DONE-entry edge.
        if (lastNib) begin
          ASeq_o_S <= workNext;
          ASeq_o_C <= sliceSum[4];
          ASeq_o_V <= (aReg[W-1] == (bReg[W-1] ^ subReg)) && (workNext[W-1] != aReg[W-1]);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Randomized and directed bench for addsub_nibble_seq (NIBBLES=4) against a
// whole-word arithmetic model with per-cycle output comparison.
module tb_addsub_nibble_seq;

  localparam int unsigned NIB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] opA = '0, opB = '0;
  logic        fSub = 1'b0;
  logic        busy, done, cOut, vOut;
  logic [15:0] sOut;

  int vectors = 0;
  int miscompares = 0;

  addsub_nibble_seq #(.NIBBLES(NIB)) dut (
    .ASeq_i_Clk  (clk),
    .ASeq_i_nRst (rst_n),
    .ASeq_i_Start(start),
    .ASeq_i_A    (opA),
    .ASeq_i_B    (opB),
    .ASeq_i_fSub (fSub),
    .ASeq_o_Busy (busy),
    .ASeq_o_Done (done),
    .ASeq_o_S    (sOut),
    .ASeq_o_C    (cOut),
    .ASeq_o_V    (vOut)
  );

  always #5 clk = ~clk;

  // Model: an operation occupies NIB cycles after acceptance, then the whole-word result appears.
  logic [15:0] mA = '0, mB = '0, eS = '0;
  logic        mSub = 1'b0, eBusy = 1'b0, eDone = 1'b0, eC = 1'b0, eV = 1'b0;
  int          mRem = 0;
  int          r;
  logic [16:0] wide;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mRem = 0; eBusy = 1'b0; eDone = 1'b0; eS = '0; eC = 1'b0; eV = 1'b0;
    end else if (mRem > 0) begin
      mRem = mRem - 1;
      if (mRem == 0) begin
        if (mSub) begin
          eS = mA - mB;
          eC = (mA >= mB);
          r  = int'($signed(mA)) - int'($signed(mB));
        end else begin
          wide = {1'b0, mA} + {1'b0, mB};
          eS   = wide[15:0];
          eC   = wide[16];
          r    = int'($signed(mA)) + int'($signed(mB));
        end
        eV    = (r > 32767) || (r < -32768);
        eDone = 1'b1;
        eBusy = 1'b0;
      end
    end else begin
      eDone = 1'b0;
      if (start) begin
        mA = opA; mB = opB; mSub = fSub; mRem = NIB; eBusy = 1'b1;
      end else begin
        eBusy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (busy !== eBusy || done !== eDone || sOut !== eS || cOut !== eC || vOut !== eV) begin
      miscompares++;
      $display("FAIL cycle t=%0t got busy=%b done=%b S=%h C=%b V=%b expected busy=%b done=%b S=%h C=%b V=%b",
               $time, busy, done, sOut, cOut, vOut, eBusy, eDone, eS, eC, eV);
    end
  end

  task automatic checkLit(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
    opA = a; opB = b; fSub = s; start = 1'b1;
  endtask

  // Waits for the result of an op whose Start is already asserted; hold keeps Start high
  // and scrambles the operand inputs while the op runs.
  task automatic finishOp(input string name, input bit hold,
                          input logic [15:0] expS, input logic expC, input logic expV);
    bit ok = 1'b0;
    int busyCnt = 0;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    checkLit({name, "_busyAfterAccept"}, {15'd0, busy}, 16'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      if (busy) busyCnt++;
      if (hold) begin opA = 16'($urandom); opB = 16'($urandom); fSub = 1'($urandom); end
    end
    if (!ok) begin
      miscompares++; vectors++;
      $display("FAIL %s_timeout got=no Done expected=Done within 12 cycles", name);
    end else begin
      checkLit({name, "_busyCycles"}, 16'(busyCnt), 16'(NIB));
      checkLit({name, "_S"}, sOut, expS);
      checkLit({name, "_C"}, {15'd0, cOut}, {15'd0, expC});
      checkLit({name, "_V"}, {15'd0, vOut}, {15'd0, expV});
    end
  endtask

  initial begin
    int doneCnt;
    #1;
    checkLit("reset_outputs", {sOut[15:3], busy, done, cOut | vOut}, 16'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(posedge clk); #1 launch(16'h1234, 16'h0FFF, 1'b0);
    finishOp("add", 1'b0, 16'h2233, 1'b0, 1'b0);
    @(posedge clk); #1 launch(16'h1234, 16'h0FFF, 1'b1);
    finishOp("sub", 1'b0, 16'h0235, 1'b1, 1'b0);
    @(posedge clk); #1 launch(16'h0000, 16'h0001, 1'b1);
    finishOp("subBorrow", 1'b0, 16'hFFFF, 1'b0, 1'b0);
    @(posedge clk); #1 launch(16'h7FFF, 16'h0001, 1'b0);
    finishOp("addOvf", 1'b0, 16'h8000, 1'b0, 1'b1);
    @(posedge clk); #1 launch(16'hFFFF, 16'h0001, 1'b0);
    finishOp("addWrap", 1'b0, 16'h0000, 1'b1, 1'b0);

    // Start held through RUN with changing operands, then a back-to-back op from DONE.
    @(posedge clk); #1 launch(16'h1234, 16'h0FFF, 1'b1);
    finishOp("holdStart", 1'b1, 16'h0235, 1'b1, 1'b0);
    launch(16'h8000, 16'h0001, 1'b1);
    finishOp("backToBack", 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Reset mid-RUN.
    @(posedge clk); #1 launch(16'h1234, 16'h0FFF, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkLit("midRunReset", {sOut[15:3], busy, done, cOut | vOut}, 16'd0);
    checkLit("midRunResetS", sOut, 16'h0000);
    #1 rst_n = 1'b1;
    doneCnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkLit("noDoneAfterReset", 16'(doneCnt), 16'd0);
    @(posedge clk); #1 launch(16'h1234, 16'h0FFF, 1'b1);
    finishOp("afterReset", 1'b0, 16'h0235, 1'b1, 1'b0);

    // Random traffic checked cycle-by-cycle against the model.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0:       begin opA = 16'h7FFF; opB = 16'($urandom_range(0, 2)); end
        1:       begin opA = 16'h8000; opB = 16'($urandom_range(0, 2)); end
        2:       begin opA = 16'($urandom); opB = opA; end
        default: begin opA = 16'($urandom); opB = 16'($urandom); end
      endcase
      fSub = 1'($urandom);
    end
    @(posedge clk); #1 start = 1'b0;
    repeat (NIB + 3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
